// File: rtl/tune_player.sv
// rtl/tune_player.sv - bus-mastering note-table player driving a memory-mapped buzzer
//
// Purpose: on start_i, fetch length_i 32-bit notes from table_i, write each note
// to the buzzer register, hold it for note[31:16] ticks of TICK_DIV clocks, then
// silence the buzzer (write 0) and pulse done_o. A bus abort sets a sticky error_o
// and ends playback with a silence write and no done_o pulse.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   start_i, stop_i       begin playback pulse, cancel playback
//   table_i, length_i     note-table base byte address, note count
//   busy_o, done_o        playback active, one-cycle completion pulse
//   error_o               sticky bus-abort flag (cleared by the next start)
//   cs_o, read_o, write_o, size_o, mode_o, address_o, data_o   bus master request
//   stall_i, abort_i, data_i                                    bus response
//
// Optional feature: TUNE_PLAYER_LOOP_EN adds input loop_i; when high at the
// last note's expiry, playback restarts from note 0 instead of silencing.

module tune_player #(
  parameter logic [31:0] BUZZER_ADDR = 32'h0002_0000,
  parameter logic [15:0] TICK_DIV    = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [31:0] table_i,
  input  logic [7:0]  length_i,
`ifdef TUNE_PLAYER_LOOP_EN
  input  logic        loop_i,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        cs_o,
  output logic        read_o,
  output logic        write_o,
  output logic [1:0]  size_o,
  output logic [1:0]  mode_o,
  output logic [31:0] address_o,
  output logic [31:0] data_o,
  input  logic        stall_i,
  input  logic [2:0]  abort_i,
  input  logic [31:0] data_i
);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WRITE, WAIT, SILENCE, DONE, ERROR} state_t;

  state_t      r_state, w_state;
  logic [31:0] r_table, w_table, r_index, w_index, r_note, w_note;
  logic [7:0]  r_length, w_length;
  logic [15:0] r_tick, r_dur;
  logic        r_error, w_error;
  logic        r_busy, r_done, r_cs, r_read, r_write;
  logic [1:0]  r_size, r_mode;
  logic [31:0] r_addr, r_data;
  logic        w_abort, w_expire, w_more, w_loop, w_cs, w_wr;

  assign w_abort  = |abort_i;
  // Duration 0 expires in the first WAIT cycle; otherwise after dur*TICK_DIV cycles.
  assign w_expire = (r_note[31:16] == 16'd0) ||
                    ((r_tick == TICK_DIV - 16'd1) && (r_dur == r_note[31:16] - 16'd1));
  assign w_more   = (r_index + 32'd1) < {24'd0, r_length};
`ifdef TUNE_PLAYER_LOOP_EN
  assign w_loop   = loop_i;
`else
  assign w_loop   = 1'b0;
`endif

  always_comb begin
    w_state  = r_state;
    w_table  = r_table;
    w_length = r_length;
    w_index  = r_index;
    w_note   = r_note;
    w_error  = r_error;
    case (r_state)
      IDLE: if (start_i) begin
        w_table  = table_i;
        w_length = length_i;
        w_index  = 32'd0;
        w_error  = 1'b0;
        w_state  = (length_i != 8'd0) ? FETCH : SILENCE;
      end
      FETCH: if (!stall_i) begin
        if (w_abort) begin
          w_error = 1'b1;
          w_state = SILENCE;
        end else begin
          w_state = stop_i ? SILENCE : CAPTURE;
        end
      end
      CAPTURE: begin
        w_note  = data_i;
        w_state = stop_i ? SILENCE : WRITE;
      end
      WRITE: if (!stall_i) begin
        if (w_abort) begin
          w_error = 1'b1;
          w_state = SILENCE;
        end else begin
          w_state = stop_i ? SILENCE : WAIT;
        end
      end
      WAIT: if (stop_i) begin
        w_state = SILENCE;
      end else if (w_expire) begin
        if (w_more) begin
          w_index = r_index + 32'd1;
          w_state = FETCH;
        end else if (w_loop) begin
          w_index = 32'd0;
          w_state = FETCH;
        end else begin
          w_state = SILENCE;
        end
      end
      // An errored playback still silences the buzzer but ends without done_o.
      SILENCE: if (!stall_i) begin
        if (w_abort) w_error = 1'b1;
        w_state = (w_abort || r_error) ? ERROR : DONE;
      end
      DONE:    w_state = IDLE;
      ERROR:   w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  assign w_cs = (w_state == FETCH) || (w_state == WRITE) || (w_state == SILENCE);
  assign w_wr = (w_state == WRITE) || (w_state == SILENCE);

  // Outputs are registered from the next-state decode so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_table  <= 32'd0;
      r_length <= 8'd0;
      r_index  <= 32'd0;
      r_note   <= 32'd0;
      r_tick   <= 16'd0;
      r_dur    <= 16'd0;
      r_error  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cs     <= 1'b0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_mode   <= 2'b00;
      r_addr   <= 32'd0;
      r_data   <= 32'd0;
    end else begin
      r_state  <= w_state;
      r_table  <= w_table;
      r_length <= w_length;
      r_index  <= w_index;
      r_note   <= w_note;
      r_error  <= w_error;
      if ((r_state == WAIT) && (w_state == WAIT)) begin
        if (r_tick == TICK_DIV - 16'd1) begin
          r_tick <= 16'd0;
          r_dur  <= r_dur + 16'd1;
        end else begin
          r_tick <= r_tick + 16'd1;
        end
      end else begin
        r_tick <= 16'd0;
        r_dur  <= 16'd0;
      end
      r_busy  <= (w_state != IDLE);
      r_done  <= (w_state == DONE);
      r_cs    <= w_cs;
      r_read  <= (w_state == FETCH);
      r_write <= w_wr;
      r_size  <= w_cs ? 2'b10 : 2'b00;
      r_mode  <= w_cs ? 2'b11 : 2'b00;
      r_addr  <= (w_state == FETCH) ? (w_table + (w_index << 2)) :
                 w_wr               ? BUZZER_ADDR : 32'd0;
      r_data  <= (w_state == WRITE) ? w_note : 32'd0;
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign error_o   = r_error;
  assign cs_o      = r_cs;
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign size_o    = r_size;
  assign mode_o    = r_mode;
  assign address_o = r_addr;
  assign data_o    = r_data;

endmodule
